// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-state encoding for the 8-bit core.
// Field positions describe the 8-bit instruction word layout.
package isa_pkg;

    localparam int PC_WIDTH   = 8;
    localparam int INST_WIDTH = 8;

    localparam logic [7:0] HALT_WORD = 8'h00;
    localparam logic [1:0] JUMP_OPC  = 2'b11;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int TGT_MSB = 5;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for fetch: redirect, local jump or increment.
// All results are reduced modulo the instruction memory depth.
module fetch_next_pc
    import isa_pkg::*;
#(
    parameter int         PC_WIDTH   = isa_pkg::PC_WIDTH,
    parameter int         INST_WIDTH = isa_pkg::INST_WIDTH,
    parameter int         MEM_DEPTH  = 8,
    parameter logic [1:0] JUMP_OPC   = isa_pkg::JUMP_OPC
) (
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [INST_WIDTH-1:0] instruction,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_target,
    output logic [PC_WIDTH-1:0]   next_pc
);

    function automatic logic [PC_WIDTH-1:0] wrap(input logic [31:0] a);
        return PC_WIDTH'(a % 32'(MEM_DEPTH));
    endfunction

    logic is_jump;

    assign is_jump = (instruction[OPC_MSB:OPC_LSB] == JUMP_OPC);

    always_comb begin
        next_pc = wrap(32'(pc) + 32'd1);
        if (redirect) begin
            next_pc = wrap(32'(redirect_target));
        end else if (is_jump) begin
            next_pc = wrap(32'(instruction[TGT_MSB:0]));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR capture, valid/ready hand-off,
// local jumps, halt detection and execute-stage redirects.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int                    PC_WIDTH   = isa_pkg::PC_WIDTH,
    parameter int                    INST_WIDTH = isa_pkg::INST_WIDTH,
    parameter int                    MEM_DEPTH  = 8,
    parameter logic [INST_WIDTH-1:0] HALT_WORD  = isa_pkg::HALT_WORD,
    parameter logic [1:0]            JUMP_OPC   = isa_pkg::JUMP_OPC
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [PC_WIDTH-1:0]   PC,
    input  logic [INST_WIDTH-1:0] Instruction,
    output logic [INST_WIDTH-1:0] IR,
    output logic                  IR_valid,
    input  logic                  ID_ready,
    input  logic                  Redirect,
    input  logic [PC_WIDTH-1:0]   Redirect_target,
    output logic                  Halted,
    output logic [7:0]            Fetch_count
);

    fetch_state_e        state;
    logic [PC_WIDTH-1:0] next_pc;
    logic                transfer;
    logic                can_load;
    logic                is_halt;

    fetch_next_pc #(
        .PC_WIDTH  (PC_WIDTH),
        .INST_WIDTH(INST_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .JUMP_OPC  (JUMP_OPC)
    ) u_next_pc (
        .pc             (PC),
        .instruction    (Instruction),
        .redirect       (Redirect),
        .redirect_target(Redirect_target),
        .next_pc        (next_pc)
    );

    assign transfer = IR_valid & ID_ready;
    assign can_load = ~IR_valid | ID_ready;
    assign is_halt  = (Instruction == HALT_WORD);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Fetch_count <= 8'd0;
        end else if (transfer && Fetch_count != 8'hFF) begin
            Fetch_count <= Fetch_count + 8'd1;
        end
    end

    // Redirect outranks everything except the START settle cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_START;
            PC       <= '0;
            IR       <= '0;
            IR_valid <= 1'b0;
            Halted   <= 1'b0;
        end else if (state != ST_START && Redirect) begin
            state    <= ST_RUN;
            PC       <= next_pc;
            IR_valid <= 1'b0;
            Halted   <= 1'b0;
        end else begin
            unique case (state)
                ST_START: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (can_load) begin
                        if (is_halt) begin
                            IR_valid <= 1'b0;
                            Halted   <= 1'b1;
                            state    <= ST_HALT;
                        end else begin
                            IR       <= Instruction;
                            IR_valid <= 1'b1;
                            PC       <= next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    if (transfer) begin
                        IR_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences,
// and randomized traffic against a behavioural fetch model.
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] PC;
    logic [7:0] Instruction;
    logic [7:0] IR;
    logic       IR_valid;
    logic       ID_ready = 1'b0;
    logic       Redirect = 1'b0;
    logic [7:0] Redirect_target = 8'h00;
    logic       Halted;
    logic [7:0] Fetch_count;

    logic [7:0] mem [8];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign Instruction = mem[PC[2:0]];

    fetch_unit dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PC             (PC),
        .Instruction    (Instruction),
        .IR             (IR),
        .IR_valid       (IR_valid),
        .ID_ready       (ID_ready),
        .Redirect       (Redirect),
        .Redirect_target(Redirect_target),
        .Halted         (Halted),
        .Fetch_count    (Fetch_count)
    );

    typedef struct {
        logic       rdy;
        logic       redir;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic [7:0] ir;
        logic       v;
        logic       h;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [18];

    // behavioural model state
    logic [7:0] m_pc, m_ir, m_cnt;
    logic       m_valid, m_halted, m_started;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] pc,
                           input logic [7:0] ir, input logic v,
                           input logic h, input logic [7:0] cnt);
        chk({tag, " pc"}, 32'(PC), 32'(pc));
        chk({tag, " ir"}, 32'(IR), 32'(ir));
        chk({tag, " valid"}, 32'(IR_valid), 32'(v));
        chk({tag, " halted"}, 32'(Halted), 32'(h));
        chk({tag, " count"}, 32'(Fetch_count), 32'(cnt));
    endtask

    // holds reset over two edges, checks cleared outputs, releases
    task automatic do_reset();
        Reset = 1'b0;
        Redirect = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        Reset = 1'b1;
        m_pc = 0; m_ir = 0; m_cnt = 0;
        m_valid = 0; m_halted = 0; m_started = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // one clock of fetch behaviour, applied with the current inputs
    task automatic model_edge();
        logic [7:0] w;
        if (m_valid && ID_ready && m_cnt != 8'hFF) m_cnt++;
        if (!m_started) begin
            m_started = 1;
        end else if (Redirect) begin
            m_pc = Redirect_target % 8;
            m_valid = 0;
            m_halted = 0;
        end else if (!m_halted && (!m_valid || ID_ready)) begin
            w = mem[m_pc % 8];
            if (w == 8'h00) begin
                m_valid = 0;
                m_halted = 1;
            end else begin
                m_ir = w;
                m_valid = 1;
                if (w[7:6] == 2'b11) m_pc = {2'b00, w[5:0]} % 8;
                else m_pc = (m_pc + 8'd1) % 8;
            end
        end
    endtask

    initial begin
        mem[0] = 8'h13; mem[1] = 8'h52; mem[2] = 8'h4b; mem[3] = 8'hc1;
        mem[4] = 8'h1c; mem[5] = 8'h5d; mem[6] = 8'h00; mem[7] = 8'h00;

        //         rdy   rdr   tgt     pc     ir     v     h     cnt
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'd0, 8'h00, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 8'd1, 8'h13, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'd2, 8'h52, 1'b1, 1'b0, 8'd1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'd2, 8'h52, 1'b1, 1'b0, 8'd1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'd2, 8'h52, 1'b1, 1'b0, 8'd1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'd2, 8'h52, 1'b1, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 8'd3, 8'h4b, 1'b1, 1'b0, 8'd2};
        tbl[7]  = '{1'b1, 1'b1, 8'h04, 8'd4, 8'h4b, 1'b0, 1'b0, 8'd3};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 8'd5, 8'h1c, 1'b1, 1'b0, 8'd3};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'd6, 8'h5d, 1'b1, 1'b0, 8'd4};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 8'd6, 8'h5d, 1'b0, 1'b1, 8'd5};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 8'd6, 8'h5d, 1'b0, 1'b1, 8'd5};
        tbl[12] = '{1'b1, 1'b1, 8'h09, 8'd1, 8'h5d, 1'b0, 1'b0, 8'd5};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 8'd2, 8'h52, 1'b1, 1'b0, 8'd5};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 8'd3, 8'h4b, 1'b1, 1'b0, 8'd6};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 8'd1, 8'hc1, 1'b1, 1'b0, 8'd7};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 8'd2, 8'h52, 1'b1, 1'b0, 8'd8};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 8'd3, 8'h4b, 1'b1, 1'b0, 8'd9};

        // run, backpressure, redirect, halt, redirect out of halt, jump
        do_reset();
        for (int i = 0; i < 18; i++) begin
            ID_ready = tbl[i].rdy;
            Redirect = tbl[i].redir;
            Redirect_target = tbl[i].tgt;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ir,
                    tbl[i].v, tbl[i].h, tbl[i].cnt);
        end
        Redirect = 1'b0;

        // asynchronous reset with an IR pending
        #3;
        Reset = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        ID_ready = 1'b1;
        step();
        chk_all("restart_start", 8'd0, 8'h00, 1'b0, 1'b0, 8'd0);
        step();
        chk_all("restart_first", 8'd1, 8'h13, 1'b1, 1'b0, 8'd0);

        // halt straight after the first instruction
        mem[1] = 8'h00;
        do_reset();
        ID_ready = 1'b1;
        repeat (2) step();
        chk_all("halt_cap", 8'd1, 8'h13, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("halt_hold%0d", i), 8'd1, 8'h13,
                    1'b0, 1'b1, 8'd1);
        end

        // wrap and saturation
        for (int i = 0; i < 8; i++) mem[i] = 8'h13;
        do_reset();
        ID_ready = 1'b1;
        step();
        for (int k = 1; k <= 300; k++) begin
            step();
            chk($sformatf("wrap_pc%0d", k), 32'(PC), 32'(k % 8));
        end
        chk("sat_count", 32'(Fetch_count), 32'hFF);

        // randomized traffic against the model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 7))
                    0: mem[i] = 8'h00;
                    1, 2: mem[i] = 8'hc0 | 8'($urandom_range(0, 63));
                    default: mem[i] = 8'($urandom_range(1, 191));
                endcase
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
                ID_ready = ($urandom_range(0, 3) != 0);
                Redirect = ($urandom_range(0, 9) == 0);
                Redirect_target = 8'($urandom_range(0, 255));
                model_edge();
                step();
                chk_all($sformatf("rnd%0d_%0d", r, c), m_pc, m_ir,
                        m_valid, m_halted, m_cnt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
